// File: rtl/biriscv_dbg_inst_gen_pkg.sv
// Shared constants and types for the debug abstract-command instruction generator.
package biriscv_dbg_inst_gen_pkg;

    localparam logic [6:0]  OPC_SYSTEM     = 7'h73;
    localparam logic [2:0]  FUNCT3_CSRRW   = 3'b001;
    localparam logic [2:0]  FUNCT3_CSRRS   = 3'b010;

    localparam logic [11:0] CSR_DSCRATCH0  = 12'h7b2;
    localparam logic [11:0] CSR_DSCRATCH1  = 12'h7b3;

    localparam logic [2:0]  CMDERR_NONE      = 3'd0;
    localparam logic [2:0]  CMDERR_NOTSUP    = 3'd2;
    localparam logic [2:0]  CMDERR_EXCEPTION = 3'd3;

    localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;
    localparam logic [15:0] REGNO_CSR_BASE = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RET,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_GPR_RD,
        OP_GPR_WR,
        OP_CSR_RD,
        OP_CSR_WR
    } op_t;

    function automatic logic [31:0] csr_inst(input logic [11:0] csr,
                                             input logic [4:0]  rs1,
                                             input logic [2:0]  funct3,
                                             input logic [4:0]  rd);
        return {csr, rs1, funct3, rd, OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/biriscv_dbg_inst_enc.sv
// Combinational encoder: (op, step, regno) -> RV32 CSR instruction word.
module biriscv_dbg_inst_enc
    import biriscv_dbg_inst_gen_pkg::*;
#(
    parameter logic [11:0] DSCRATCH0_ADDR = CSR_DSCRATCH0,
    parameter logic [11:0] DSCRATCH1_ADDR = CSR_DSCRATCH1
) (
    input  op_t         op,
    input  logic [1:0]  step,
    input  logic [11:0] regno,
    output logic [31:0] inst
);

    // CSR sequences bracket the transfer with an x1 save (step 0) and restore (step 3).
    always_comb begin
        inst = '0;
        case (op)
            OP_GPR_RD: inst = csr_inst(DSCRATCH0_ADDR, regno[4:0], FUNCT3_CSRRW, 5'd0);
            OP_GPR_WR: inst = csr_inst(DSCRATCH0_ADDR, 5'd0, FUNCT3_CSRRS, regno[4:0]);
            OP_CSR_RD: begin
                case (step)
                    2'd0:    inst = csr_inst(DSCRATCH1_ADDR, 5'd1, FUNCT3_CSRRW, 5'd0);
                    2'd1:    inst = csr_inst(regno,          5'd0, FUNCT3_CSRRS, 5'd1);
                    2'd2:    inst = csr_inst(DSCRATCH0_ADDR, 5'd1, FUNCT3_CSRRW, 5'd0);
                    default: inst = csr_inst(DSCRATCH1_ADDR, 5'd0, FUNCT3_CSRRS, 5'd1);
                endcase
            end
            default: begin
                case (step)
                    2'd0:    inst = csr_inst(DSCRATCH1_ADDR, 5'd1, FUNCT3_CSRRW, 5'd0);
                    2'd1:    inst = csr_inst(DSCRATCH0_ADDR, 5'd0, FUNCT3_CSRRS, 5'd1);
                    2'd2:    inst = csr_inst(regno,          5'd1, FUNCT3_CSRRW, 5'd0);
                    default: inst = csr_inst(DSCRATCH1_ADDR, 5'd0, FUNCT3_CSRRS, 5'd1);
                endcase
            end
        endcase
    end

endmodule

// File: rtl/biriscv_dbg_inst_gen.sv
// Debug abstract-command instruction generator: encodes access-register commands into
// injected CSR instructions. Define BIRISCV_DBG_CSR_ACCESS_EN to support CSR targets.
module biriscv_dbg_inst_gen
    import biriscv_dbg_inst_gen_pkg::*;
#(
    parameter logic [11:0] DSCRATCH0_ADDR = CSR_DSCRATCH0,
    parameter logic [11:0] DSCRATCH1_ADDR = CSR_DSCRATCH1,
    parameter int unsigned RETIRE_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_accept_o,
    input  logic [15:0] cmd_regno_i,
    input  logic        cmd_write_i,
    input  logic        cmd_transfer_i,
    input  logic [2:0]  cmd_size_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    input  logic        inst_accept_i,
    input  logic        inst_retire_i,
    input  logic        inst_fault_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  cmderr_o
);

`ifdef BIRISCV_DBG_CSR_ACCESS_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    localparam int STEP_W = CSR_EN ? 2 : 1;
    localparam int TMR_W  = (RETIRE_TIMEOUT > 0) ? $clog2(RETIRE_TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    op_t                 op_q, op_d;
    logic [11:0]         regno_q, regno_d;
    logic [2:0]          err_q, err_d;
    logic [TMR_W-1:0]    tmr_q;

    logic        gpr_hit;
    logic        csr_hit;
    logic [1:0]  step_ext;
    logic [1:0]  last_step;
    logic        op_is_csr;
    logic        restore_ok;
    logic        timeout;
    logic [31:0] enc_inst;

    assign gpr_hit    = (cmd_regno_i[15:5] == REGNO_GPR_BASE[15:5]);
    assign csr_hit    = CSR_EN && (cmd_regno_i[15:12] == REGNO_CSR_BASE[15:12]);
    assign step_ext   = 2'(step_q);
    assign op_is_csr  = (op_q == OP_CSR_RD) || (op_q == OP_CSR_WR);
    assign last_step  = op_is_csr ? 2'd3 : 2'd0;
    // x1 is live in dscratch1 only after the save retired and before the restore issued.
    assign restore_ok = CSR_EN && op_is_csr && ((step_ext == 2'd1) || (step_ext == 2'd2));
    assign timeout    = (RETIRE_TIMEOUT != 0) && (tmr_q == TMR_W'(RETIRE_TIMEOUT));

    biriscv_dbg_inst_enc #(
        .DSCRATCH0_ADDR (DSCRATCH0_ADDR),
        .DSCRATCH1_ADDR (DSCRATCH1_ADDR)
    ) u_enc (
        .op    (op_q),
        .step  (step_ext),
        .regno (regno_q),
        .inst  (enc_inst)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        regno_d = regno_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = gpr_hit ? (cmd_write_i ? OP_GPR_WR : OP_GPR_RD)
                                      : (cmd_write_i ? OP_CSR_WR : OP_CSR_RD);
                    regno_d = cmd_regno_i[11:0];
                    step_d  = '0;
                    err_d   = CMDERR_NONE;
                    if (!cmd_transfer_i) begin
                        state_d = ST_DONE;
                    end else if ((cmd_size_i != 3'd2) || !(gpr_hit || csr_hit)) begin
                        state_d = ST_DONE;
                        err_d   = CMDERR_NOTSUP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (inst_accept_i) begin
                    state_d = ST_WAIT_RET;
                end
            end
            ST_WAIT_RET: begin
                if (inst_fault_i || timeout) begin
                    err_d = CMDERR_EXCEPTION;
                    if (restore_ok) begin
                        step_d  = STEP_W'(2'd3);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (inst_retire_i) begin
                    if (step_ext == last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            op_q    <= OP_GPR_RD;
            regno_q <= '0;
            err_q   <= CMDERR_NONE;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            regno_q <= regno_d;
            err_q   <= err_d;
        end
    end

    // Retire watchdog restarts with every accepted instruction and sticks at its limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q <= '0;
        end else if ((state_q == ST_ISSUE) && inst_accept_i) begin
            tmr_q <= '0;
        end else if ((state_q == ST_WAIT_RET) && !timeout) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    assign cmd_accept_o = (state_q == ST_IDLE) && cmd_valid_i;
    assign inst_valid_o = (state_q == ST_ISSUE);
    assign inst_o       = inst_valid_o ? enc_inst : 32'd0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign cmderr_o     = done_o ? err_q : CMDERR_NONE;

endmodule

// File: tb/tb_biriscv_dbg_inst_gen.sv
// Randomised self-checking bench for biriscv_dbg_inst_gen against a sequence-level model.
module tb_biriscv_dbg_inst_gen;

`ifdef BIRISCV_DBG_CSR_ACCESS_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    localparam logic [11:0] DS0 = 12'h7b2;
    localparam logic [11:0] DS1 = 12'h7b3;
    localparam logic [2:0]  RW  = 3'b001;
    localparam logic [2:0]  RS  = 3'b010;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_accept_o;
    logic [15:0] cmd_regno_i;
    logic        cmd_write_i;
    logic        cmd_transfer_i;
    logic [2:0]  cmd_size_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        inst_accept_i;
    logic        inst_retire_i;
    logic        inst_fault_i;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  cmderr_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_words[$];
    logic [2:0]  exp_err[$];

    biriscv_dbg_inst_gen #(
        .DSCRATCH0_ADDR (DS0),
        .DSCRATCH1_ADDR (DS1),
        .RETIRE_TIMEOUT (255)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_accept_o   (cmd_accept_o),
        .cmd_regno_i    (cmd_regno_i),
        .cmd_write_i    (cmd_write_i),
        .cmd_transfer_i (cmd_transfer_i),
        .cmd_size_i     (cmd_size_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_accept_i  (inst_accept_i),
        .inst_retire_i  (inst_retire_i),
        .inst_fault_i   (inst_fault_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cmderr_o       (cmderr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'h73};
    endfunction

    // Model: list of words the core must see, and the final error, given which issue faults.
    task automatic build_expect(input logic [15:0] regno, input logic write,
                                input logic [2:0] size, input logic transfer, input int fault_idx);
        logic [31:0] seq[$];
        logic [11:0] c;
        logic [4:0]  n;
        bit          gpr;
        bit          csr;
        c   = regno[11:0];
        n   = regno[4:0];
        gpr = (regno >= 16'h1000) && (regno <= 16'h101F);
        csr = CSR_EN && (regno <= 16'h0FFF);
        seq = {};
        if (!transfer) begin
            exp_err.push_back(3'd0);
        end else if ((size != 3'd2) || !(gpr || csr)) begin
            exp_err.push_back(3'd2);
        end else begin
            if (gpr)
                seq = write ? '{enc(DS0, 5'd0, RS, n)} : '{enc(DS0, n, RW, 5'd0)};
            else if (!write)
                seq = '{enc(DS1, 5'd1, RW, 5'd0), enc(c, 5'd0, RS, 5'd1),
                        enc(DS0, 5'd1, RW, 5'd0), enc(DS1, 5'd0, RS, 5'd1)};
            else
                seq = '{enc(DS1, 5'd1, RW, 5'd0), enc(DS0, 5'd0, RS, 5'd1),
                        enc(c, 5'd1, RW, 5'd0), enc(DS1, 5'd0, RS, 5'd1)};
            if (fault_idx < 0 || fault_idx >= seq.size()) begin
                foreach (seq[i]) exp_words.push_back(seq[i]);
                exp_err.push_back(3'd0);
            end else begin
                for (int i = 0; i <= fault_idx; i++) exp_words.push_back(seq[i]);
                if (seq.size() == 4 && (fault_idx == 1 || fault_idx == 2))
                    exp_words.push_back(seq[3]);
                exp_err.push_back(3'd3);
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] regno, input logic write, input logic [2:0] size,
                                 input logic transfer, input int fault_idx, input bit use_timeout,
                                 input int hold);
        int issued  = 0;
        int delay   = 0;
        int cyc     = 0;
        int acc_cyc = 0;
        int hold_n  = hold;
        bit waiting = 0;
        bit issues;
        build_expect(regno, write, size, transfer, fault_idx);
        issues = (exp_words.size() != 0);
        cmd_regno_i    = regno;
        cmd_write_i    = write;
        cmd_size_i     = size;
        cmd_transfer_i = transfer;
        cmd_valid_i    = 1'b1;
        #1;
        check("cmd_accept", {31'd0, cmd_accept_o}, 32'd1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        if (!issues) check("early_done", {31'd0, done_o}, 32'd1);
        while (!done_o && cyc < 3000) begin
            inst_accept_i = 1'b0;
            inst_retire_i = 1'b0;
            inst_fault_i  = 1'b0;
            if (waiting && inst_valid_o) begin
                waiting = 1'b0;
                if (use_timeout) check("timeout_latency", 32'(cyc - acc_cyc), 32'd257);
            end
            if (waiting) begin
                if (delay == 0) begin
                    waiting = 1'b0;
                    if (issued - 1 == fault_idx) begin
                        inst_fault_i  = 1'b1;
                        inst_retire_i = 1'($urandom_range(0, 1));
                    end else begin
                        inst_retire_i = 1'b1;
                    end
                end else begin
                    delay--;
                end
            end else if (inst_valid_o) begin
                if (hold_n > 0) begin
                    hold_n--;
                end else if ($urandom_range(0, 2) != 0) begin
                    inst_accept_i = 1'b1;
                    waiting       = 1'b1;
                    acc_cyc       = cyc;
                    issued++;
                    delay = (use_timeout && issued - 1 == fault_idx) ? 100000 : int'($urandom_range(0, 3));
                end
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        if (use_timeout && waiting) check("timeout_latency", 32'(cyc - acc_cyc), 32'd257);
        check("cmd_completes", {31'd0, done_o}, 32'd1);
        inst_accept_i = 1'b0;
        inst_retire_i = 1'b0;
        inst_fault_i  = 1'b0;
        @(posedge clk_i); #1;
        check("idle_after_done", {31'd0, busy_o}, 32'd0);
    endtask

    logic        prev_valid = 1'b0;
    logic        prev_acc   = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] prev_inst  = 32'd0;

    // Single compare process: words at handshake, error at completion, protocol rules.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (inst_valid_o && prev_valid && !prev_acc)
                check("inst_stable", inst_o, prev_inst);
            if (inst_valid_o && inst_accept_i) begin
                if (exp_words.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_inst actual=%h required=none", inst_o);
                end else begin
                    check("inst_word", inst_o, exp_words.pop_front());
                end
            end
            if (done_o) begin
                if (exp_err.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra_done actual=1 required=0");
                end else begin
                    check("cmderr", {29'd0, cmderr_o}, {29'd0, exp_err.pop_front()});
                end
                check("words_left", 32'(exp_words.size()), 32'd0);
                check("done_single", {31'd0, prev_done}, 32'd0);
            end
            if (inst_valid_o || done_o)
                check("busy", {31'd0, busy_o}, 32'd1);
            prev_valid = inst_valid_o;
            prev_acc   = inst_accept_i;
            prev_done  = done_o;
            prev_inst  = inst_o;
        end
    end

    task automatic checkOutput();
        check("rst_busy",   {31'd0, busy_o},       32'd0);
        check("rst_valid",  {31'd0, inst_valid_o}, 32'd0);
        check("rst_done",   {31'd0, done_o},       32'd0);
        check("rst_cmderr", {29'd0, cmderr_o},     32'd0);
        check("rst_inst",   inst_o,                32'd0);
        check("rst_accept", {31'd0, cmd_accept_o}, 32'd0);
    endtask

    initial begin
        logic [15:0] regno;
        int          fidx;
        int          n;
        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_regno_i = '0; cmd_write_i = 1'b0;
        cmd_transfer_i = 1'b0; cmd_size_i = 3'd2;
        inst_accept_i = 1'b0; inst_retire_i = 1'b0; inst_fault_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput();
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        n = exp_words.size();
        build_expect(16'h1005, 1'b0, 3'd2, 1'b1, -1);
        check("model_rd_x5", exp_words[n], 32'h7B229073);
        exp_words.delete(); exp_err.delete();
        applyStimulus(16'h1005, 1'b0, 3'd2, 1'b1, -1, 1'b0, 0);

        build_expect(16'h100A, 1'b1, 3'd2, 1'b1, -1);
        check("model_wr_x10", exp_words[0], 32'h7B202573);
        exp_words.delete(); exp_err.delete();
        applyStimulus(16'h100A, 1'b1, 3'd2, 1'b1, -1, 1'b0, 3);

        build_expect(16'h0300, 1'b0, 3'd2, 1'b1, -1);
`ifdef BIRISCV_DBG_CSR_ACCESS_EN
        check("model_csr_w0", exp_words[0], 32'h7B309073);
        check("model_csr_w1", exp_words[1], 32'h300020F3);
        check("model_csr_w2", exp_words[2], 32'h7B209073);
        check("model_csr_w3", exp_words[3], 32'h7B3020F3);
`else
        check("model_csr_err", {29'd0, exp_err[0]}, 32'd2);
`endif
        exp_words.delete(); exp_err.delete();
        applyStimulus(16'h0300, 1'b0, 3'd2, 1'b1, -1, 1'b0, 0);

        applyStimulus(16'h1005, 1'b0, 3'd3, 1'b1, -1, 1'b0, 0);
        applyStimulus(16'h1020, 1'b0, 3'd2, 1'b1, -1, 1'b0, 0);
        applyStimulus(16'h1005, 1'b1, 3'd2, 1'b0, -1, 1'b0, 0);

        if (CSR_EN) begin
            applyStimulus(16'h0300, 1'b0, 3'd2, 1'b1, 1, 1'b0, 0);
            applyStimulus(16'h0300, 1'b0, 3'd2, 1'b1, 1, 1'b1, 0);
            applyStimulus(16'h0341, 1'b1, 3'd2, 1'b1, 0, 1'b0, 0);
            applyStimulus(16'h0341, 1'b1, 3'd2, 1'b1, 3, 1'b0, 0);
        end else begin
            applyStimulus(16'h1007, 1'b0, 3'd2, 1'b1, 0, 1'b0, 0);
            applyStimulus(16'h1007, 1'b0, 3'd2, 1'b1, 0, 1'b1, 0);
        end

        regno = CSR_EN ? 16'h0300 : 16'h1005;
        build_expect(regno, 1'b0, 3'd2, 1'b1, -1);
        cmd_regno_i = regno; cmd_write_i = 1'b0; cmd_size_i = 3'd2; cmd_transfer_i = 1'b1;
        cmd_valid_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 10 && !inst_valid_o; i++) begin
            @(posedge clk_i); #1;
        end
        inst_accept_i = 1'b1;
        @(posedge clk_i); #1;
        inst_accept_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("mid_rst_busy",  {31'd0, busy_o},       32'd0);
        check("mid_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("mid_rst_done",  {31'd0, done_o},       32'd0);
        rst_i = 1'b0;
        exp_words.delete(); exp_err.delete();
        applyStimulus(16'h1003, 1'b0, 3'd2, 1'b1, -1, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       regno = 16'h1000 | 16'($urandom_range(0, 31));
                1:       regno = 16'($urandom_range(0, 16'h0FFF));
                2:       regno = 16'($urandom_range(16'h1020, 16'h1FFF));
                default: regno = 16'($urandom);
            endcase
            fidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            applyStimulus(regno, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd2,
                          ($urandom_range(0, 5) != 0), fidx, 1'b0, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
